// File: rtl/mmio_write_buffer.sv
// Write buffer that captures CPU stores into an MMIO window and drains them over valid/ready.
// Define MMIO_WBUF_COALESCE_EN to merge a store into the newest entry when the address matches.
module mmio_write_buffer #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     data_write,
   input  logic [31:0]              data_address,
   input  logic [31:0]              data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_address,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     clear_overflow
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          overflow_q, overflow_d;

   logic          match;
   logic          push_req;
   logic          pop;
   logic          coalesce;
   logic          push_ok;
   logic          mem_we;
   logic [PW-1:0] newest_idx;
   logic [PW-1:0] mem_idx;

   always_comb begin
      // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned and infers a latch.
      match      = (data_address & MMIO_MASK) == (MMIO_BASE & MMIO_MASK);
      push_req   = data_write & match;
      pop        = !empty_q & out_ready;
      newest_idx = wr_ptr_q - PW'(1);
`ifdef MMIO_WBUF_COALESCE_EN
      // The newest entry cannot be merged into when it is also the head leaving this cycle.
      coalesce   = push_req & !empty_q & (addr_mem[newest_idx] == data_address)
                 & !((count_q == CW'(1)) & pop);
`else
      coalesce   = 1'b0;
`endif
      push_ok    = push_req & !coalesce & (!full_q | pop);
      mem_we     = push_ok | coalesce;
      mem_idx    = coalesce ? newest_idx : wr_ptr_q;

      wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d    = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d     = (count_d == CW'(DEPTH));
      empty_d    = (count_d == '0);

      // A drop sets the sticky flag and outranks a simultaneous clear.
      overflow_d = overflow_q;
      if (push_req & !coalesce & full_q & !pop) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage has no reset; its contents are only visible through a valid pointer range.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         addr_mem[mem_idx] <= data_address;
         data_mem[mem_idx] <= data;
      end
   end

   assign out_valid   = !empty_q;
   assign out_address = empty_q ? '0 : addr_mem[rd_ptr_q];
   assign out_data    = empty_q ? '0 : data_mem[rd_ptr_q];
   assign count       = count_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_mmio_write_buffer.sv
// Scoreboard bench for mmio_write_buffer: a queue-based model predicts drained entries and status.
// Honours MMIO_WBUF_COALESCE_EN the same way the design does.
module tb_mmio_write_buffer;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] MASK  = 32'hFFFF_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   data_write;
   logic [31:0]            data_address;
   logic [31:0]            data;
   logic                   out_valid;
   logic                   out_ready;
   logic [31:0]            out_address;
   logic [31:0]            out_data;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   overflow;
   logic                   clear_overflow;

   int     checks = 0;
   int     errors = 0;
   entry_t exp_q[$];
   int     mcount;
   logic   movf;
   entry_t mon_e;

   always #5 clk = ~clk;

   mmio_write_buffer #(
      .DEPTH(DEPTH), .MMIO_BASE(BASE), .MMIO_MASK(MASK)
   ) dut (
      .clk(clk), .reset(reset), .data_write(data_write), .data_address(data_address),
      .data(data), .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
      .out_data(out_data), .count(count), .full(full), .empty(empty),
      .overflow(overflow), .clear_overflow(clear_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      check("count", 32'(count), 32'(mcount));
      check("full", 32'(full), 32'(mcount == DEPTH));
      check("empty", 32'(empty), 32'(mcount == 0));
      check("out_valid", 32'(out_valid), 32'(mcount != 0));
      check("overflow", 32'(overflow), 32'(movf));
      if (mcount == 0) begin
         check("idle_addr", out_address, 32'h0);
         check("idle_data", out_data, 32'h0);
      end
   endtask

   // Called at posedge+2: drive one cycle of stimulus, predict the edge, then check the result.
   task automatic step(input logic dw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr);
      logic   p, preq, coal, was_full, pok;
      entry_t ent;
      data_write     = dw;
      data_address   = a;
      data           = d;
      out_ready      = rdy;
      clear_overflow = clr;

      p        = (mcount != 0) && rdy;
      preq     = dw && ((a & MASK) == (BASE & MASK));
      was_full = (mcount == DEPTH);
      coal     = 1'b0;
`ifdef MMIO_WBUF_COALESCE_EN
      if (preq && mcount != 0 && exp_q[exp_q.size()-1].addr == a && !(mcount == 1 && p))
         coal = 1'b1;
`endif
      pok = preq && !coal && (!was_full || p);
      if (coal) begin
         ent      = exp_q[exp_q.size()-1];
         ent.data = d;
         exp_q[exp_q.size()-1] = ent;
      end
      if (pok) exp_q.push_back('{addr: a, data: d});
      mcount = mcount + int'(pok) - int'(p);
      if (preq && !coal && was_full && !p) movf = 1'b1;
      else if (clr) movf = 1'b0;

      @(posedge clk);
      #2;
      check_state();
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      mcount = 0;
      movf   = 1'b0;
   endtask

   // Monitor: whenever a handshake is about to happen, the head must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 32'(out_valid), 32'h0);
         end else begin
            mon_e = exp_q.pop_front();
            check("drain_addr", out_address, mon_e.addr);
            check("drain_data", out_data, mon_e.data);
         end
      end
   end

   initial begin
      reset = 1'b0;
      data_write = 1'b0; data_address = '0; data = '0;
      out_ready = 1'b0; clear_overflow = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_state();
      reset = 1'b1;

      // First store appears one edge later
      step(1'b1, 32'hFFFF_0004, 32'h0000_00AA, 1'b0, 1'b0);
      check("t1_addr", out_address, 32'hFFFF_0004);
      check("t1_data", out_data, 32'h0000_00AA);
      check("t1_count", 32'(count), 32'd1);
      idle(1'b1);

      // Out-of-window store is ignored
      step(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check("outside_count", 32'(count), 32'd0);
      check("outside_valid", 32'(out_valid), 32'd0);

      // Fill, overflow, drain, clear
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, BASE | 32'(32'h100 + i * 4), 32'(32'h1000 + i), 1'b0, 1'b0);
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd8);
      step(1'b1, BASE | 32'h200, 32'h999, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check("ovf_clear", 32'(overflow), 32'd0);

      // Push and pop together while full
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, BASE | 32'(32'h400 + i * 4), 32'(32'h3000 + i), 1'b0, 1'b0);
      step(1'b1, 32'hFFFF_0020, 32'h55, 1'b1, 1'b0);
      check("fullpp_count", 32'(count), 32'd8);
      check("fullpp_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      check("fullpp_drained", 32'(exp_q.size()), 32'd0);

      // Streaming with wrap of both pointers
      for (int i = 0; i < 20; i++) begin
         step(1'b1, BASE | 32'(32'h800 + i * 4), 32'(32'h2000 + i), 1'b1, 1'b0);
         check("stream_le1", 32'(count <= 1), 32'd1);
      end
      idle(1'b1);

      // Same-address stores back to back
      step(1'b1, 32'hFFFF_0008, 32'h11, 1'b0, 1'b0);
      step(1'b1, 32'hFFFF_0008, 32'h22, 1'b0, 1'b0);
`ifdef MMIO_WBUF_COALESCE_EN
      check("coal_count", 32'(count), 32'd1);
      check("coal_head", out_data, 32'h22);
`else
      check("coal_count", 32'(count), 32'd2);
      check("coal_head", out_data, 32'h11);
`endif
      idle(1'b1);
      idle(1'b1);

      // Reset in the middle of a drain
      for (int i = 0; i < 5; i++)
         step(1'b1, BASE | 32'(32'hA00 + i * 4), 32'(32'h5000 + i), 1'b0, 1'b0);
      idle(1'b1);
      out_ready = 1'b0;
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_addr", out_address, 32'h0);
      @(posedge clk);
      #2;
      check_state();
      reset = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        dw, rdy, clr;
         logic [31:0] a;
         dw  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) == 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 4) == 0) a = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
         else                          a = BASE | 32'($urandom_range(0, 7) * 4);
         step(dw, a, $urandom, rdy, clr);
      end

      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
      check("final_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
